// File: rtl/rv32i_reg_file.sv
// RV32I integer register file: 32 x XLEN registers, two combinational read ports, one synchronous write port.
// Optional macro REG_FILE_BYPASS_EN adds same-cycle write-to-read forwarding on both read ports.
module rv32i_reg_file #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic [AW-1:0]   rd_addr,
   input  logic            rd_we,
   input  logic [XLEN-1:0] rd_data,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data
);

   logic [XLEN-1:0] regs [NREG];
   logic            write_fire;
   logic [XLEN-1:0] rs1_stored;
   logic [XLEN-1:0] rs2_stored;

   // x0 is never written, so its slot keeps the reset value of zero forever.
   assign write_fire = rd_we && (rd_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (write_fire) begin
         regs[rd_addr] <= rd_data;
      end
   end

   always_comb begin
      rs1_stored = '0;
      rs2_stored = '0;
      if (rs1_addr != '0) begin
         rs1_stored = regs[rs1_addr];
      end
      if (rs2_addr != '0) begin
         rs2_stored = regs[rs2_addr];
      end
   end

`ifdef REG_FILE_BYPASS_EN
   // Forward the pending write so decode sees it ahead of the edge; never during reset.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rst_n) begin
         rs1_data = (write_fire && (rs1_addr == rd_addr)) ? rd_data : rs1_stored;
         rs2_data = (write_fire && (rs2_addr == rd_addr)) ? rd_data : rs2_stored;
      end
   end
`else
   // Storage is cleared asynchronously, but gate on rst_n so reads are zero for the whole reset window.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rst_n) begin
         rs1_data = rs1_stored;
         rs2_data = rs2_stored;
      end
   end
`endif

endmodule

// File: tb/tb_rv32i_reg_file.sv
// Self-checking bench for rv32i_reg_file: reset sweep, vector table, random traffic and async-reset sequences.
// Expected read values come from the vector table and from a reference array kept by the bench.
module tb_rv32i_reg_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic [31:0] rd_data;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;

   rv32i_reg_file #(.XLEN(32), .NREG(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_addr  (rd_addr),
      .rd_we    (rd_we),
      .rd_data  (rd_data),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t        tbl [9];
   logic [31:0] mdl [32];
   logic [31:0] exp_q [$];
   int          n_checks;
   int          n_fails;

   // scoreboard
   task automatic check(input string name, input logic [31:0] act);
      logic [31:0] exp_v;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fails++;
         $display("FAIL %s: scoreboard empty, got %h", name, act);
      end else begin
         exp_v = exp_q.pop_front();
         if (act !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
         end
      end
   endtask

   function automatic logic [31:0] pre_val(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (!rst_n) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
      if (rd_we && rd_addr != 5'd0 && a == rd_addr) return rd_data;
`endif
      return mdl[a];
   endfunction

   function automatic logic [31:0] post_val(input logic [4:0] a);
      if (a == 5'd0 || !rst_n) return 32'h0;
      return mdl[a];
   endfunction

   task automatic model_edge();
      if (rst_n && rd_we && rd_addr != 5'd0) mdl[rd_addr] = rd_data;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
   endtask

   // driver: present one write/read cycle, check before and after the edge
   task automatic drive_cycle(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic use_tbl, input logic [31:0] e1, input logic [31:0] e2);
      @(negedge clk);
      rd_we = we; rd_addr = rd; rd_data = wd; rs1_addr = a1; rs2_addr = a2;
      exp_q.push_back(pre_val(a1));
      exp_q.push_back(pre_val(a2));
      #1;
      check("pre_edge_rs1", rs1_data);
      check("pre_edge_rs2", rs2_data);
      @(posedge clk);
      model_edge();
      exp_q.push_back(use_tbl ? e1 : post_val(a1));
      exp_q.push_back(use_tbl ? e2 : post_val(a2));
      #1;
      check("post_edge_rs1", rs1_data);
      check("post_edge_rs2", rs2_data);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      clear_model();
      tbl[0] = '{1'b1, 5'd1,  32'hA5A5A5A5, 5'd1,  5'd0,  32'hA5A5A5A5, 32'h00000000};
      tbl[1] = '{1'b0, 5'd1,  32'h00000000, 5'd1,  5'd1,  32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd1,  32'h00000000, 32'hA5A5A5A5};
      tbl[3] = '{1'b0, 5'd2,  32'h12345678, 5'd2,  5'd1,  32'h00000000, 32'hA5A5A5A5};
      tbl[4] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd2,  32'hDEADBEEF, 32'h00000000};
      tbl[5] = '{1'b1, 5'd5,  32'h00000005, 5'd31, 5'd5,  32'hDEADBEEF, 32'h00000005};
      tbl[6] = '{1'b1, 5'd3,  32'hCAFEF00D, 5'd3,  5'd3,  32'hCAFEF00D, 32'hCAFEF00D};
      tbl[7] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd31, 32'h11111111, 32'hDEADBEEF};
      tbl[8] = '{1'b0, 5'd5,  32'h22222222, 5'd5,  5'd3,  32'h11111111, 32'hCAFEF00D};

      rst_n = 1'b0; rd_we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // reset sweep over every address on both ports
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(31 - a);
         exp_q.push_back(32'h0);
         exp_q.push_back(32'h0);
         #1;
         check("reset_rs1", rs1_data);
         check("reset_rs2", rs2_data);
      end

      for (int i = 0; i < 9; i++) begin
         drive_cycle(tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].a1, tbl[i].a2, 1'b1, tbl[i].e1, tbl[i].e2);
      end

      // random traffic, frequently reading the address being written
      for (int i = 0; i < 60; i++) begin
         logic [4:0] r;
         r = 5'($urandom_range(0, 31));
         drive_cycle(1'($urandom_range(0, 1)), r, $urandom,
                     ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 1'b0, 32'h0, 32'h0);
      end

      // async reset between edges clears storage without a clock
      drive_cycle(1'b1, 5'd1, 32'hA5A5A5A5, 5'd1, 5'd0, 1'b0, 32'h0, 32'h0);
      #2;
      rd_we = 1'b0; rs1_addr = 5'd1;
      exp_q.push_back(32'hA5A5A5A5);
      #1;
      check("before_async_reset", rs1_data);
      rst_n = 1'b0;
      clear_model();
      exp_q.push_back(32'h0);
      #1;
      check("async_clear_no_edge", rs1_data);

      // write presented during reset is ignored and never forwarded
      rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'h77777777; rs2_addr = 5'd7;
      exp_q.push_back(32'h0);
      #1;
      check("in_reset_no_forward", rs2_data);
      @(posedge clk);
      model_edge();
      exp_q.push_back(32'h0);
      #1;
      check("write_in_reset_ignored", rs2_data);

      // release mid-cycle; first write lands on the next edge
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      exp_q.push_back(pre_val(5'd7));
      #1;
      check("release_pre_edge", rs2_data);
      @(posedge clk);
      model_edge();
      exp_q.push_back(32'h77777777);
      exp_q.push_back(32'h0);
      #1;
      check("first_write_after_release", rs2_data);
      check("x1_cleared_by_reset", rs1_data);

      @(negedge clk);
      rd_we = 1'b0;
      drive_cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd31, 1'b0, 32'h0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/rv32i_reg_file.md
Name: rv32i_reg_file

Overview:
- RV32I integer register file: 32 general-purpose registers x0..x31, XLEN bits each.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Sits in the decode/writeback path of the core: decode drives the read addresses, writeback drives the write port.
- x0 is hardwired to zero.

Parameters:
- XLEN, 32, register width in bits.
- NREG, 32, number of registers; address width is clog2(NREG) = 5 at default.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_addr  input  5  read port 1 register index.
- rs2_addr  input  5  read port 2 register index.
- rd_addr  input  5  write port register index.
- rd_we  input  1  write enable for the rd port.
- rd_data  input  XLEN  write data.
- rs1_data  output  XLEN  read port 1 data.
- rs2_data  output  XLEN  read port 2 data.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all registers x1..x31 to 0, independent of clk.
  - While rst_n is low, rs1_data and rs2_data read 0 for every address, and all writes are ignored.
  - Reset deasserting mid-cycle: the first write takes effect on the next rising clk edge with rst_n high.
- Write:
  - On rising clk edge with rst_n high and rd_we=1, reg[rd_addr] <= rd_data.
  - Write latency is 1 edge; the new value is visible on the read ports after that edge.
  - rd_we=0: no register changes.
- x0:
  - A write with rd_addr=0 is discarded; x0 never holds a nonzero value.
  - Reads of address 0 always return 0.
- Read:
  - Purely combinational (asynchronous): rsN_data = reg[rsN_addr], with no clock latency.
  - Both ports are independent; the same address on both ports returns the same value.
- Same-cycle read/write to the same nonzero address (no bypass):
  - Before the edge, the read returns the old contents.
  - After the edge, the read returns the new contents.
- Addresses are always in range (5-bit, 32 entries); no out-of-range handling is needed.
- No X propagation: all storage is defined after reset.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If rd_we=1, rd_addr!=0 and rsN_addr==rd_addr, then rsN_data = rd_data combinationally in the same cycle, ahead of the clock edge.
  - Applies independently to rs1 and rs2.
  - rd_addr=0 is never forwarded; reads of x0 still return 0.
  - Forwarding is suppressed while rst_n is low.
- Not defined: no forwarding; read ports show stored contents only, per the Behaviour section.
- The storage update is identical in both builds.

Test Plan:
1. Reset check: assert rst_n=0, then release; sweep rs1_addr and rs2_addr over 0..31 -> every read returns 32'h0.
2. Write and read back: rd_we=1, rd_addr=1, rd_data=32'hA5A5A5A5 for one rising edge, then rd_we=0.
   - rs1_addr=1 -> rs1_data=32'hA5A5A5A5 with no wait.
   - Then rs2_addr=1 -> rs2_data=32'hA5A5A5A5.
   - rs1 still reads 32'hA5A5A5A5.
3. x0 immunity: write rd_addr=0, rd_data=32'hFFFFFFFF, rd_we=1 -> rs1_addr=0 reads 32'h0.
4. Write-enable gating and port independence:
   - rd_we=0, rd_addr=2, rd_data=32'h12345678 -> x2 stays 0.
   - Write x31=32'hDEADBEEF and x5=32'h00000005.
   - Read rs1=31, rs2=5 simultaneously -> 32'hDEADBEEF and 32'h00000005.
5. Async reset mid-operation:
   - After writing x1=32'hA5A5A5A5, pulse rst_n low between clock edges -> rs1_data (addr 1) drops to 0 immediately, without a clock edge.
   - A write presented with rd_we=1 while rst_n is low has no effect.
6. Same-cycle read/write hazard: rs1_addr=3 while writing x3=32'hCAFEF00D.
   - Without REG_FILE_BYPASS_EN: before the edge reads old 0; after the edge reads 32'hCAFEF00D.
   - With REG_FILE_BYPASS_EN: reads 32'hCAFEF00D before the edge.
